// File: rtl/display_pkg.sv
// Shared types, codes and BCD helpers for the seven-segment display sequencer.
package display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONV_PC = 2'd1,
        ST_CONV_X5 = 2'd2,
        ST_SHOW    = 2'd3
    } state_t;

    localparam logic [3:0] ESTADO_SHOW = 4'b1100;
    localparam logic [3:0] ESTADO_IDLE = 4'b0000;
    localparam logic [3:0] DIGIT_BLANK = 4'hF;
    localparam logic [3:0] FINAL_WRAP  = 4'd9;

    // Shift-add-3 correction applied to one BCD nibble before each shift.
    function automatic logic [3:0] add3(input logic [3:0] nib);
        logic [3:0] res;
        if (nib >= 4'd5) res = nib + 4'd3;
        else             res = nib;
        return res;
    endfunction

    // Tens/ones digits of a 3-digit BCD value; anything above 99 blanks both.
    function automatic logic [7:0] bcd_to_digits(input logic [11:0] bcd);
        logic [7:0] res;
        if (bcd[11:8] != 4'd0) res = {DIGIT_BLANK, DIGIT_BLANK};
        else                   res = bcd[7:0];
        return res;
    endfunction

endpackage

// File: rtl/display_ctrl_if.sv
// Snapshot request/operands in, BCD digits and update status out to the display decoder.
// The update counter is named final_count because "final" is a reserved word.
interface display_ctrl_if #(parameter int W = 8);
    logic         start;
    logic [W-1:0] pc_in;
    logic [W-1:0] x5_in;
    logic [3:0]   pc1;
    logic [3:0]   pc2;
    logic [3:0]   x5part1;
    logic [3:0]   x5part2;
    logic [3:0]   final_count;
    logic [3:0]   estado;
    logic         busy;
    logic         done;

    modport master (
        input  start, pc_in, x5_in,
        output pc1, pc2, x5part1, x5part2, final_count, estado, busy, done
    );

    modport slave (
        output start, pc_in, x5_in,
        input  pc1, pc2, x5part1, x5part2, final_count, estado, busy, done
    );
endinterface

// File: rtl/bin2bcd_serial.sv
// Serial shift-add-3 binary-to-BCD datapath; the owner sequences load/step.
// bcd_out shows the BCD field the current step produces, so the owner can capture it on the last step.
module bin2bcd_serial
    import display_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] bin_in,
    input  logic         step,
    output logic [11:0]  bcd_out
);

    logic [W+11:0] shift_r;
    logic [W+11:0] adj_s;
    logic [W+11:0] shift_next_s;

    // Correct every BCD nibble, then shift the whole {bcd, bin} register left by one.
    always_comb begin
        adj_s            = shift_r;
        adj_s[W+3:W]     = add3(shift_r[W+3:W]);
        adj_s[W+7:W+4]   = add3(shift_r[W+7:W+4]);
        adj_s[W+11:W+8]  = add3(shift_r[W+11:W+8]);
        shift_next_s     = {adj_s[W+10:0], 1'b0};
    end

    assign bcd_out = shift_next_s[W+11:W];

    // Converter register; a load takes priority over a step on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_r <= '0;
        end else if (load) begin
            shift_r <= {12'd0, bin_in};
        end else if (step) begin
            shift_r <= shift_next_s;
        end else begin
            shift_r <= shift_r;
        end
    end

endmodule

// File: rtl/display_ctrl.sv
// Display sequencer: snapshots PC/x5 on start, converts both through one shared
// BCD converter, then shows the digits for one cycle with the update code.
module display_ctrl
    import display_pkg::*;
#(
    parameter int W = 8
) (
    input  logic              clk,
    input  logic              reset,
    display_ctrl_if.master    bus
);

    localparam logic [3:0] ITER_LAST = 4'(W - 1);

    state_t       state_r;
    state_t       state_next_s;
    logic [W-1:0] x5_op_r;
    logic [3:0]   iter_r;
    logic         last_iter_s;
    logic         conv_load_s;
    logic         conv_step_s;
    logic [W-1:0] conv_bin_s;
    logic [11:0]  conv_bcd_s;
    logic [7:0]   digits_s;
    logic         busy_s;
    logic         done_s;
    logic [3:0]   estado_s;

    assign last_iter_s = (iter_r == ITER_LAST);
    assign digits_s    = bcd_to_digits(conv_bcd_s);

    // The PC snapshot lives in the converter itself; only x5 needs a holding register.
    bin2bcd_serial #(.W(W)) u_bcd (
        .clk     (clk),
        .reset   (reset),
        .load    (conv_load_s),
        .bin_in  (conv_bin_s),
        .step    (conv_step_s),
        .bcd_out (conv_bcd_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_r <= ST_IDLE;
        else       state_r <= state_next_s;
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE:    state_next_s = bus.start   ? ST_CONV_PC : ST_IDLE;
            ST_CONV_PC: state_next_s = last_iter_s ? ST_CONV_X5 : ST_CONV_PC;
            ST_CONV_X5: state_next_s = last_iter_s ? ST_SHOW    : ST_CONV_X5;
            ST_SHOW:    state_next_s = ST_IDLE;
            default:    state_next_s = ST_IDLE;
        endcase
    end

    // Converter sequencing and status outputs decoded from the upcoming state.
    always_comb begin
        conv_load_s = 1'b0;
        conv_step_s = 1'b0;
        conv_bin_s  = x5_op_r;
        case (state_r)
            ST_IDLE: begin
                conv_load_s = bus.start;
                conv_bin_s  = bus.pc_in;
            end
            ST_CONV_PC: begin
                conv_step_s = 1'b1;
                conv_load_s = last_iter_s;
            end
            ST_CONV_X5: conv_step_s = 1'b1;
            default:    conv_step_s = 1'b0;
        endcase
        busy_s   = (state_next_s != ST_IDLE);
        done_s   = (state_next_s == ST_SHOW);
        estado_s = (state_next_s == ST_SHOW) ? ESTADO_SHOW : ESTADO_IDLE;
    end

    // Iteration counter and x5 operand snapshot.
    always_ff @(posedge clk) begin
        if (reset) begin
            iter_r  <= 4'd0;
            x5_op_r <= '0;
        end else begin
            if ((state_r == ST_CONV_PC || state_r == ST_CONV_X5) && !last_iter_s) iter_r <= iter_r + 4'd1;
            else                                                                  iter_r <= 4'd0;
            if (state_r == ST_IDLE && bus.start) x5_op_r <= bus.x5_in;
            else                                 x5_op_r <= x5_op_r;
        end
    end

    // Registered outputs; digits only move on the last step of each conversion.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.pc1         <= DIGIT_BLANK;
            bus.pc2         <= DIGIT_BLANK;
            bus.x5part1     <= DIGIT_BLANK;
            bus.x5part2     <= DIGIT_BLANK;
            bus.final_count <= 4'd0;
            bus.estado      <= ESTADO_IDLE;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
        end else begin
            bus.estado <= estado_s;
            bus.busy   <= busy_s;
            bus.done   <= done_s;
            if (state_r == ST_CONV_PC && last_iter_s) begin
                bus.pc1 <= digits_s[7:4];
                bus.pc2 <= digits_s[3:0];
            end
            if (state_r == ST_CONV_X5 && last_iter_s) begin
                bus.x5part1     <= digits_s[7:4];
                bus.x5part2     <= digits_s[3:0];
                bus.final_count <= (bus.final_count == FINAL_WRAP) ? 4'd0 : bus.final_count + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_display_ctrl.sv
// Directed, scoreboard-driven bench for display_ctrl with W=8.
module tb_display_ctrl;
    import display_pkg::*;

    localparam int W        = 8;
    localparam int SHOW_LAT = 2 * W + 1;
    localparam int PERIOD   = 2 * W + 2;

    typedef struct packed {
        logic [3:0] pc1;
        logic [3:0] pc2;
        logic [3:0] x1;
        logic [3:0] x2;
        logic [3:0] fin;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    display_ctrl_if #(.W(W)) bus ();

    display_ctrl #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   vectors   = 0;
    int   errors    = 0;
    int   fin_model = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_digits(input int v);
        logic [7:0] r;
        if (v > 99) r = 8'hFF;
        else        r = {4'(v / 10), 4'(v % 10)};
        return r;
    endfunction

    task automatic push(input int pc, input int x5);
        exp_t       e;
        logic [7:0] dp;
        logic [7:0] dx;
        fin_model = (fin_model + 1) % 10;
        dp = ref_digits(pc);
        dx = ref_digits(x5);
        e.pc1 = dp[7:4];
        e.pc2 = dp[3:0];
        e.x1  = dx[7:4];
        e.x2  = dx[3:0];
        e.fin = 4'(fin_model);
        sb.push_back(e);
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic check_show(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_pc1"},    32'(bus.pc1),         32'(e.pc1));
            chk({tag, "_pc2"},    32'(bus.pc2),         32'(e.pc2));
            chk({tag, "_x5p1"},   32'(bus.x5part1),     32'(e.x1));
            chk({tag, "_x5p2"},   32'(bus.x5part2),     32'(e.x2));
            chk({tag, "_final"},  32'(bus.final_count), 32'(e.fin));
            chk({tag, "_estado"}, 32'(bus.estado),      32'(4'b1100));
            chk({tag, "_busy"},   32'(bus.busy),        32'd1);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_pc1"},    32'(bus.pc1),         32'hF);
        chk({tag, "_pc2"},    32'(bus.pc2),         32'hF);
        chk({tag, "_x5p1"},   32'(bus.x5part1),     32'hF);
        chk({tag, "_x5p2"},   32'(bus.x5part2),     32'hF);
        chk({tag, "_final"},  32'(bus.final_count), 32'd0);
        chk({tag, "_estado"}, 32'(bus.estado),      32'd0);
        chk({tag, "_busy"},   32'(bus.busy),        32'd0);
        chk({tag, "_done"},   32'(bus.done),        32'd0);
    endtask

    task automatic run_one(input string tag, input int pc, input int x5);
        int         n;
        logic [7:0] dp;
        bus.pc_in = W'(pc);
        bus.x5_in = W'(x5);
        push(pc, x5);
        dp = ref_digits(pc);
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        n = 1;
        while (bus.done !== 1'b1 && n < 60) begin
            cyc();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(SHOW_LAT));
        check_show(tag);
        cyc();
        chk({tag, "_idle_busy"},   32'(bus.busy),   32'd0);
        chk({tag, "_idle_done"},   32'(bus.done),   32'd0);
        chk({tag, "_idle_estado"}, 32'(bus.estado), 32'd0);
        chk({tag, "_idle_pc1"},    32'(bus.pc1),    32'(dp[7:4]));
    endtask

    initial begin
        int ndone;
        int n;
        logic show_exp;

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.pc_in = '0;
        bus.x5_in = '0;
        cyc();
        cyc();
        reset = 1'b0;
        check_reset_vals("reset");

        run_one("t37_5", 37, 5);
        run_one("t99_100", 99, 100);
        run_one("t255_0", 255, 0);

        // Ignored starts at cycles 3 and 17, operand change at cycle 2.
        bus.pc_in = 8'd12;
        bus.x5_in = 8'd34;
        push(12, 34);
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        chk("ign_busy_c1", 32'(bus.busy), 32'd1);
        cyc();
        bus.pc_in = 8'd200;
        bus.x5_in = 8'd250;
        cyc();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        ndone = 0;
        for (int c = 4; c <= 40; c++) begin
            if (bus.done === 1'b1) begin
                ndone++;
                chk("ign_latency", 32'(c), 32'(SHOW_LAT));
                check_show("ign");
            end
            bus.start = (c == SHOW_LAT) ? 1'b1 : 1'b0;
            cyc();
        end
        bus.start = 1'b0;
        chk("ign_done_count", 32'(ndone), 32'd1);

        // Reset mid-conversion discards everything.
        bus.pc_in = 8'd45;
        bus.x5_in = 8'd67;
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        for (int c = 1; c < 10; c++) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        fin_model = 0;
        check_reset_vals("midrst");
        ndone = 0;
        for (int c = 0; c < 25; c++) begin
            if (bus.done === 1'b1) ndone++;
            cyc();
        end
        chk("midrst_no_done", 32'(ndone), 32'd0);
        run_one("after_rst", 45, 67);

        // Start held high: 11 back-to-back updates from a fresh reset.
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        fin_model = 0;
        bus.pc_in = 8'd58;
        bus.x5_in = 8'd91;
        for (int k = 0; k < 11; k++) push(58, 91);
        bus.start = 1'b1;
        ndone = 0;
        n = 0;
        for (int c = 1; c <= 11 * PERIOD + 20; c++) begin
            cyc();
            show_exp = ((c % PERIOD) == SHOW_LAT) && (c <= 11 * PERIOD);
            chk("held_done",   32'(bus.done),   32'(show_exp));
            chk("held_estado", 32'(bus.estado), show_exp ? 32'hC : 32'h0);
            if (show_exp) begin
                ndone++;
                check_show("held");
                if (ndone == 11) bus.start = 1'b0;
            end
            if (bus.done === 1'b1) n++;
        end
        chk("held_done_count", 32'(n), 32'd11);
        chk("held_sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/display_ctrl.md
# display_ctrl

Sequencer for the FPGA testbench seven-segment display path. On a `start` pulse it snapshots the datapath PC and register x5 as binary values. It converts both values to two BCD digits each, reusing one serial shift-add-3 converter, and then presents the digits, an update counter and the `estado` update code to the digit-to-segment display decoder. It sits between the datapath/testbench control and the display decoder and owns the only BCD converter in that path.

## Interface
Parameters:
- `W`, default 8: width of `pc_in`/`x5_in`; legal range 4..8.

Ports:
- `clk`  in  1: the single clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: snapshot request, sampled only in IDLE.
- `pc_in`  in  W: PC value, unsigned.
- `x5_in`  in  W: register x5 value, unsigned.
- `pc1`, `pc2`  out  4: PC tens and ones BCD digits.
- `x5part1`, `x5part2`  out  4: x5 tens and ones BCD digits.
- `final`  out  4: update counter, 0..9.
- `estado`  out  4: 4'b1100 during SHOW, 4'b0000 otherwise.
- `busy`  out  1: high in CONV_PC, CONV_X5 and SHOW.
- `done`  out  1: one-cycle pulse, high in SHOW.

## Operation
- FSM states: IDLE, CONV_PC, CONV_X5, SHOW. All outputs are registered or decoded from state only.
- IDLE:
  - `start`=1 latches `pc_in` and `x5_in` into operand registers.
  - Loads the converter with the PC operand and enters CONV_PC.
  - `start`=0 stays in IDLE.
- CONV_PC: runs W converter iterations.
  - Each iteration adds 3 to every BCD nibble ≥5, then shifts the {BCD[11:0], bin} register left by 1.
  - On the last iteration, writes the tens/ones digits to `pc1`/`pc2`, reloads the converter with the x5 operand and enters CONV_X5.
- CONV_X5: same W iterations; results go to `x5part1`/`x5part2`; then enters SHOW.
- Overflow: if the hundreds nibble is nonzero (value >99), both digits of that value are 4'hF. The decoder blanks 4'hF.
- SHOW: lasts exactly 1 cycle.
  - `estado`=4'b1100, `done`=1, `busy`=1.
  - `final` increments on entry, wrapping 9→0.
  - Returns to IDLE.
- `start` asserted outside IDLE is ignored; there is no queuing.
- Input changes after the latching edge do not affect the result.
- Digit outputs change only at the CONV_PC→CONV_X5 and CONV_X5→SHOW edges. They hold their values through SHOW and IDLE.

## Timing
- Reset values:
  - State IDLE.
  - `pc1`, `pc2`, `x5part1`, `x5part2` = 4'hF.
  - `final` = 4'd0.
  - `estado` = 4'b0000.
  - `busy` = 0, `done` = 0.
  - Operand and converter registers = 0.
- Reset is synchronous and overrides everything. Reset asserted mid-conversion returns to IDLE at the next edge with all reset values; partial results are discarded.
- Latency: `start` sampled at edge 0.
  - CONV_PC occupies cycles 1..W.
  - CONV_X5 occupies cycles W+1..2W.
  - SHOW is cycle 2W+1.
  - IDLE again at cycle 2W+2.
  - For W=8: SHOW at cycle 17.
- The display decoder captures the digits at the edge ending SHOW (end of cycle 2W+1). Digits are already stable for the whole of SHOW.
- With `start` held high, updates repeat every 2W+2 cycles (18 for W=8).
- `reset` and `start` in the same cycle: reset wins.

## Structure
- Shared package `display_pkg`:
  - State enum.
  - `ESTADO_SHOW` = 4'b1100, `ESTADO_IDLE` = 4'b0000.
  - `DIGIT_BLANK` = 4'hF.
  - `FINAL_WRAP` = 9.
- Sub-module `bin2bcd_serial`, instantiated once and time-shared between the PC and x5 conversions.
  - Ports: `clk`, `reset`, `load`, `bin_in[W-1:0]`, `step`, `bcd_out[11:0]`.
  - Purely the shift-add-3 datapath; the iteration counter lives in `display_ctrl`.

## Test plan
- Reset, then `pc_in`=37, `x5_in`=5, one-cycle `start` (W=8):
  - Cycle 17: `estado`=1100, `done`=1.
  - Digits 3,7,0,5; `final`=1.
- `pc_in`=99, `x5_in`=100:
  - `pc1`/`pc2`=9/9.
  - `x5part1`/`x5part2`=F/F.
  - Also check `pc_in`=255 → F/F.
- `start` pulses at cycles 3 and 17 after an accepted start: both ignored; exactly one `done` pulse.
- Change `pc_in` at cycle 2 of a conversion: result uses the value latched at the start edge.
- `reset` at cycle 10 of a conversion:
  - Next cycle: all reset values, no `done`.
  - A subsequent `start` converts correctly.
- `start` held high for 11 updates:
  - `done` period is 18 cycles.
  - `final` sequence 1..9,0,1.
  - `estado`=1100 only in SHOW cycles.
